// File: rtl/global_params.sv
// Shared FP32 format constants, extended-mantissa bit positions and the packer FSM encoding.
package global_params;

  localparam int EXP_BITS  = 8;
  localparam int MANT_BITS = 23;
  localparam int MANT_W    = MANT_BITS + 4;
  localparam int PACK_BITS = 1 + EXP_BITS + MANT_BITS;

  localparam logic [EXP_BITS-1:0] EXP_MAX = {EXP_BITS{1'b1}};

  localparam int IDX_CARRY  = MANT_BITS + 3;
  localparam int IDX_HIDDEN = MANT_BITS + 2;
  localparam int IDX_GUARD  = 1;
  localparam int IDX_STICKY = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } pack_state_t;

  function automatic logic [PACK_BITS-1:0] pack_word(
    input logic                 sign,
    input logic [EXP_BITS-1:0]  exp,
    input logic [MANT_BITS-1:0] frac
  );
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/rne_rounder.sv
// Combinational round-to-nearest-even on a significand with guard and sticky bits.
module rne_rounder #(
  parameter int SIG_BITS = 24
) (
  input  logic [SIG_BITS-1:0] sig,
  input  logic                guard,
  input  logic                sticky,
  output logic [SIG_BITS-1:0] rounded,
  output logic                carry,
  output logic                inexact
);

  logic                up_s;
  logic [SIG_BITS:0]   sum_s;

  // Ties go up only when the LSB is odd, which keeps the result even.
  always_comb begin
    up_s    = guard & (sticky | sig[0]);
    sum_s   = {1'b0, sig} + {{SIG_BITS{1'b0}}, up_s};
    rounded = sum_s[SIG_BITS-1:0];
    carry   = sum_s[SIG_BITS];
    inexact = guard | sticky;
  end

endmodule

// File: rtl/fp_result_packer.sv
// Iterative normalize / round-to-nearest-even / pack stage producing an FP32 word
// from the add/sub datapath's extended mantissa, with valid/ready on both sides.
module fp_result_packer
  import global_params::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_BITS-1:0]  in_exp,
  input  logic [MANT_BITS+3:0] in_mant,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 flag_overflow,
  output logic                 flag_underflow,
  output logic                 flag_inexact
);

  // One spare exponent bit absorbs the +1 steps from carry and rounding.
  localparam int EW = EXP_BITS + 1;

  pack_state_t          state_r;
  logic                 sign_r;
  logic [EW-1:0]        exp_r;
  logic [MANT_W-1:0]    mant_r;
  logic                 subnormal_r;
  logic                 out_valid_r;
  logic [WIDTH-1:0]     result_r;
  logic                 overflow_r;
  logic                 underflow_r;
  logic                 inexact_r;

  logic [MANT_BITS:0]   rnd_sig_s;
  logic                 rnd_carry_s;
  logic                 rnd_inexact_s;
  logic [EW-1:0]        rnd_exp_s;
  logic [MANT_BITS-1:0] rnd_frac_s;
  logic                 rnd_ovf_s;
  logic                 rnd_unf_s;

  rne_rounder #(
    .SIG_BITS (MANT_BITS + 1)
  ) u_rne_rounder (
    .sig     (mant_r[IDX_HIDDEN:IDX_GUARD+1]),
    .guard   (mant_r[IDX_GUARD]),
    .sticky  (mant_r[IDX_STICKY]),
    .rounded (rnd_sig_s),
    .carry   (rnd_carry_s),
    .inexact (rnd_inexact_s)
  );

  // Exponent/fraction after rounding, including subnormal promotion and overflow detection.
  always_comb begin
    rnd_frac_s = rnd_sig_s[MANT_BITS-1:0];
    if (subnormal_r) begin
      rnd_exp_s = rnd_sig_s[MANT_BITS] ? EW'(1) : EW'(0);
    end else if (rnd_carry_s) begin
      rnd_exp_s  = exp_r + EW'(1);
      rnd_frac_s = {MANT_BITS{1'b0}};
    end else begin
      rnd_exp_s = exp_r;
    end
    rnd_ovf_s = (rnd_exp_s >= {1'b0, EXP_MAX});
    rnd_unf_s = subnormal_r && !rnd_sig_s[MANT_BITS];
  end

  // Control FSM with registered result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      sign_r      <= 1'b0;
      exp_r       <= {EW{1'b0}};
      mant_r      <= {MANT_W{1'b0}};
      subnormal_r <= 1'b0;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      inexact_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            sign_r      <= in_sign;
            exp_r       <= {1'b0, in_exp};
            mant_r      <= in_mant;
            subnormal_r <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            inexact_r   <= 1'b0;
            // Inf/NaN pass straight through with their payload untouched.
            if (in_exp == EXP_MAX) begin
              result_r    <= WIDTH'(pack_word(in_sign, EXP_MAX, in_mant[IDX_HIDDEN-1:IDX_GUARD+1]));
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              state_r <= ST_NORM;
            end
          end
        end
        ST_NORM: begin
          if (mant_r == {MANT_W{1'b0}}) begin
            result_r    <= WIDTH'(pack_word(sign_r, {EXP_BITS{1'b0}}, {MANT_BITS{1'b0}}));
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else if (mant_r[IDX_CARRY]) begin
            mant_r <= {1'b0, mant_r[MANT_W-1:2], mant_r[1] | mant_r[0]};
            exp_r  <= exp_r + EW'(1);
          end else if (!mant_r[IDX_HIDDEN] && (exp_r > EW'(1))) begin
            mant_r <= {mant_r[MANT_W-2:0], 1'b0};
            exp_r  <= exp_r - EW'(1);
          end else begin
            subnormal_r <= !mant_r[IDX_HIDDEN];
            state_r     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (rnd_ovf_s) begin
            result_r <= WIDTH'(pack_word(sign_r, EXP_MAX, {MANT_BITS{1'b0}}));
          end else begin
            result_r <= WIDTH'(pack_word(sign_r, rnd_exp_s[EXP_BITS-1:0], rnd_frac_s));
          end
          overflow_r  <= rnd_ovf_s;
          underflow_r <= rnd_unf_s;
          inexact_r   <= rnd_inexact_s;
          out_valid_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready must drop with reset itself and come back in the first cycle after release.
  assign in_ready       = (state_r == ST_IDLE) && !rst;
  assign out_valid      = out_valid_r;
  assign result         = result_r;
  assign flag_overflow  = overflow_r;
  assign flag_underflow = underflow_r;
  assign flag_inexact   = inexact_r;

endmodule

// File: tb/tb_fp_result_packer.sv
// Scoreboard bench for fp_result_packer: expected words, flags and latency are queued at
// drive time and compared when the output handshake completes.
module tb_fp_result_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_overflow;
  logic        flag_underflow;
  logic        flag_inexact;

  fp_result_packer #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign        (in_sign),
    .in_exp         (in_exp),
    .in_mant        (in_mant),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .flag_overflow  (flag_overflow),
    .flag_underflow (flag_underflow),
    .flag_inexact   (flag_inexact)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;   // {overflow, underflow, inexact}
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Called at a negedge; returns the cycle index of the accept cycle.
  task automatic drive_op(input logic s, input logic [7:0] e, input logic [26:0] m,
                          input logic [31:0] res, input logic [2:0] fl, input int lat,
                          output int acc);
    int n;
    exp_t item;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("in_ready_before_drive", {31'd0, in_ready}, 32'd1);
    item.res   = res;
    item.flags = fl;
    item.lat   = lat;
    sb_q.push_back(item);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    acc      = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect_op(input string tag, input int acc, input int hold);
    int   n;
    exp_t item;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() == 0) begin
      check_val({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      item = sb_q.pop_front();
      check_val({tag, "_latency"}, cyc - acc, item.lat);
      check_val({tag, "_result"}, result, item.res);
      check_val({tag, "_flags"}, {29'd0, flag_overflow, flag_underflow, flag_inexact},
                {29'd0, item.flags});
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check_val({tag, "_hold_result"}, result, item.res);
        check_val({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
        check_val({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val({tag, "_valid_dropped"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int acc;
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_mant   = 27'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_result", result, 32'd0);
    check_val("rst_flags", {29'd0, flag_overflow, flag_underflow, flag_inexact}, 32'd0);
    rst = 1'b0;
    #1;
    check_val("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    drive_op(1'b0, 8'h7F, 27'h2000000, 32'h3F800000, 3'b000, 3, acc);
    collect_op("one", acc, 0);
    drive_op(1'b0, 8'h7F, 27'h4000000, 32'h40000000, 3'b000, 4, acc);
    collect_op("carry", acc, 0);
    drive_op(1'b0, 8'd130, 27'h0000004, 32'h35800000, 3'b000, 26, acc);
    collect_op("shift23", acc, 0);
    drive_op(1'b0, 8'h7F, 27'h2000006, 32'h3F800002, 3'b001, 3, acc);
    collect_op("tie_odd", acc, 0);
    drive_op(1'b0, 8'h7F, 27'h2000002, 32'h3F800000, 3'b001, 3, acc);
    collect_op("tie_even", acc, 0);
    drive_op(1'b0, 8'h7F, 27'h3FFFFFE, 32'h40000000, 3'b001, 3, acc);
    collect_op("round_carry", acc, 0);
    drive_op(1'b0, 8'hFE, 27'h4000000, 32'h7F800000, 3'b100, 4, acc);
    collect_op("overflow", acc, 0);
    drive_op(1'b0, 8'h01, 27'h1000000, 32'h00400000, 3'b010, 3, acc);
    collect_op("subnormal", acc, 0);
    drive_op(1'b0, 8'hFF, 27'h0000008, 32'h7F800002, 3'b000, 1, acc);
    collect_op("special", acc, 0);
    drive_op(1'b1, 8'h7F, 27'h0000000, 32'h80000000, 3'b000, 2, acc);
    collect_op("neg_zero_hold", acc, 5);

    // Abandon a long operation with reset partway through.
    in_sign  = 1'b0;
    in_exp   = 8'd130;
    in_mant  = 27'h0000004;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check_val("abort_busy_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check_val("abort_release_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_val("abort_no_out_valid", seen, 32'd0);

    drive_op(1'b0, 8'h7F, 27'h2000000, 32'h3F800000, 3'b000, 3, acc);
    collect_op("after_abort", acc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
